// File: rtl/demux_sel_sequencer_pkg.sv
// Shared constants and types for the demux select sequencer and related routing blocks.
package demux_sel_sequencer_pkg;

  localparam int SEL_W = 3;
  localparam int N_OUT = 1 << SEL_W;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/demux_sel_sequencer_lsb_first_finder.sv
// Combinational priority encoder: index of the lowest set bit, plus any/last flags.
module lsb_first_finder #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             last
);

  // Scan from the top down so the lowest set bit is the final assignment.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  always_comb begin
    any  = |vec;
    last = any && ((vec & (vec - N'(1))) == '0);
  end

endmodule

// File: rtl/demux_sel_sequencer.sv
// Serialises one masked parallel word onto a single data line with a matching demux select.
// N_OUT must equal 2**SEL_W.
module demux_sel_sequencer #(
  parameter int SEL_W = demux_sel_sequencer_pkg::SEL_W,
  parameter int N_OUT = demux_sel_sequencer_pkg::N_OUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  output logic             ready,
  input  logic [N_OUT-1:0] data_in,
  input  logic [N_OUT-1:0] mask_in,
  output logic [SEL_W-1:0] sel,
  output logic             dout,
  output logic             dout_en,
  output logic             busy,
  output logic             done
);
  import demux_sel_sequencer_pkg::*;

  state_e             state_q, state_d;
  logic [N_OUT-1:0]   data_q, data_d;
  logic [N_OUT-1:0]   pend_q, pend_d;
  logic [SEL_W-1:0]   idx;
  logic               pend_any, pend_last;

  lsb_first_finder #(.N(N_OUT), .IDX_W(SEL_W)) u_finder (
    .vec  (pend_q),
    .idx  (idx),
    .any  (pend_any),
    .last (pend_last)
  );

  // Next-state: capture on accept, retire one pending channel per SHIFT cycle.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          data_d  = data_in;
          pend_d  = mask_in;
          state_d = (|mask_in) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        pend_d[idx] = 1'b0;
        // !pend_any cannot occur in normal flow; it just keeps SHIFT from sticking.
        if (pend_last || !pend_any) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and word registers; reset abandons any word in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
    end
  end

  // Outputs decoded from registered state; sel/dout forced low between beats.
  always_comb begin
    ready   = (state_q == IDLE);
    busy    = (state_q != IDLE);
    dout_en = (state_q == SHIFT);
    done    = (state_q == DONE);
    sel     = dout_en ? idx : '0;
    dout    = dout_en & data_q[idx];
  end

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Scoreboard bench for demux_sel_sequencer: expected beats/done pushed on accept, popped on output.
module tb_demux_sel_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid;
  logic       ready;
  logic [7:0] data_in;
  logic [7:0] mask_in;
  logic [2:0] sel;
  logic       dout;
  logic       dout_en;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit is_done;
    int sel;
    bit dout;
  } exp_t;

  exp_t sbq[$];

  demux_sel_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .valid   (valid),
    .ready   (ready),
    .data_in (data_in),
    .mask_in (mask_in),
    .sel     (sel),
    .dout    (dout),
    .dout_en (dout_en),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: on acceptance, one beat per set mask bit (lowest first), then a done event.
  task automatic push_word(input logic [7:0] d, input logic [7:0] m);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        e.is_done = 1'b0;
        e.sel     = i;
        e.dout    = d[i];
        sbq.push_back(e);
      end
    end
    e.is_done = 1'b1;
    e.sel     = 0;
    e.dout    = 1'b0;
    sbq.push_back(e);
  endtask

  // Leaves valid high; returns one cycle after the accepting edge.
  task automatic send(input logic [7:0] d, input logic [7:0] m, output int waits);
    valid   = 1'b1;
    data_in = d;
    mask_in = m;
    waits   = 0;
    while (!ready && waits < 40) begin
      tick();
      waits++;
    end
    if (!ready) chk("accept_timeout", 32'd0, 32'd1);
    else        push_word(d, m);
    tick();
  endtask

  task automatic drain();
    int n = 0;
    valid = 1'b0;
    while ((sbq.size() != 0 || !ready) && n < 50) begin
      tick();
      n++;
    end
    chk("drain_empty", sbq.size(), 0);
  endtask

  // Output monitor: compares every beat/done against the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      if (!dout_en) chk("idle_line", {sel, dout}, 4'd0);
      if (dout_en || done) begin
        if (sbq.size() == 0) begin
          chk("spurious_out", {dout_en, done}, 2'b00);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (e.is_done) begin
            chk("done_evt", {dout_en, done}, 2'b01);
          end else begin
            chk("beat_en", dout_en, 1'b1);
            chk("beat_sel", sel, e.sel);
            chk("beat_dout", dout, e.dout);
          end
        end
      end
    end
  end

  initial begin
    int w, w2;
    reset = 1'b1; valid = 1'b0; data_in = '0; mask_in = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dout_en", dout_en, 1'b0);
    chk("rst_sel_dout", {sel, dout}, 4'd0);

    // Reset and valid together: nothing captured.
    reset = 1'b1; valid = 1'b1; data_in = 8'hFF; mask_in = 8'hFF;
    tick();
    reset = 1'b0; valid = 1'b0;
    chk("rstvld_ready", ready, 1'b1);
    chk("rstvld_busy", busy, 1'b0);
    tick();
    chk("rstvld_still_idle", {busy, dout_en}, 2'b00);

    // Full word.
    send(8'hA5, 8'hFF, w);
    valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk("full_en", dout_en, 1'b1);
      chk("full_sel", sel, c - 1);
      tick();
    end
    chk("full_done", done, 1'b1);
    tick();
    chk("full_ready", ready, 1'b1);

    // Sparse mask.
    send(8'h80, 8'h81, w);
    valid = 1'b0;
    chk("sparse_b0", {dout_en, sel, dout}, {1'b1, 3'd0, 1'b0});
    tick();
    chk("sparse_b1", {dout_en, sel, dout}, {1'b1, 3'd7, 1'b1});
    tick();
    chk("sparse_done", {done, dout_en}, 2'b10);
    tick();

    // Empty mask.
    send(8'h5A, 8'h00, w);
    valid = 1'b0;
    chk("empty_done", {done, dout_en}, 2'b10);
    tick();
    chk("empty_ready", ready, 1'b1);

    // Input stability with held valid.
    send(8'h0F, 8'hFF, w);
    tick();
    data_in = 8'hFF; mask_in = 8'h00;
    send(8'h55, 8'h01, w2);
    chk("stab_accept_wait", w2, 8);
    drain();

    // Reset during the 3rd beat.
    send(8'hC3, 8'hFF, w);
    valid = 1'b0;
    tick(); tick();
    chk("midrst_beat3", {dout_en, sel}, {1'b1, 3'd2});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sbq.delete();
    chk("midrst_dout_en", dout_en, 1'b0);
    chk("midrst_sel", sel, 3'd0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", ready, 1'b1);
    repeat (12) tick();

    // Back-to-back with held valid.
    send(8'h02, 8'h03, w);
    send(8'h01, 8'h03, w2);
    chk("b2b_first_wait", w, 0);
    chk("b2b_second_wait", w2, 3);
    valid = 1'b0;
    tick(); tick();
    chk("b2b_done2", done, 1'b1);
    drain();

    // Random words through the scoreboard.
    for (int k = 0; k < 20; k++) begin
      send(8'($urandom), 8'($urandom), w);
      if ($urandom_range(0, 1) == 0) valid = 1'b0;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux_sel_sequencer.md
Name: demux_sel_sequencer

Overview:
- Upstream driver for the 1-to-8 demultiplexer: accepts one parallel word plus a channel mask over a valid/ready handshake.
- Streams the word out one bit per cycle on a single data line, with a matching select code.
- The downstream demux distributes each bit to its channel.
- Channels are visited lowest index first; masked-off channels are skipped.

Parameters:
- SEL_W, 3, width of the select code driven to the demux.
- N_OUT, 8, number of demux channels; must equal 2**SEL_W.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- valid  input  1  upstream word available.
- ready  output  1  sequencer can accept a word this cycle.
- data_in  input  N_OUT  word to distribute; bit i goes to channel i.
- mask_in  input  N_OUT  channel enable; bit i = 1 means channel i is driven.
- sel  output  SEL_W  select code to the demux.
- dout  output  1  data bit to the demux input.
- dout_en  output  1  sel/dout carry a valid beat this cycle.
- busy  output  1  a word is in progress (SHIFT or DONE).
- done  output  1  one-cycle pulse after the last beat of a word.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (reset). All outputs are registered or decoded from registered state.
- Reset values, effective the cycle after a reset edge:
  - state = IDLE; ready = 1; busy = 0; done = 0; dout_en = 0; sel = 0; dout = 0.
  - Captured data and pending mask cleared.
- IDLE:
  - ready = 1.
  - On valid & ready: capture data_in into data_q and mask_in into pend_q.
  - If mask_in ≠ 0, go to SHIFT; else go to DONE.
- SHIFT:
  - ready = 0; busy = 1.
  - Each cycle: idx = lowest set bit of pend_q; sel = idx; dout = data_q[idx]; dout_en = 1; clear pend_q[idx].
  - When the beat clears the last pending bit, go to DONE.
- DONE:
  - Exactly one cycle: done = 1, busy = 1, ready = 0, dout_en = 0. Then go to IDLE.
- Idle-line rule: whenever dout_en = 0, sel = 0 and dout = 0, so the demux drives all channels low.
- Latency and throughput:
  - First beat appears the cycle after acceptance.
  - A word with k enabled channels takes k beat cycles plus 1 DONE cycle.
  - Minimum word-to-word spacing is k + 2 cycles (accept, k beats, done).
- Input stability: data_in and mask_in are sampled only at acceptance. Changes to them while busy have no effect.
- Held valid: valid held high while busy is ignored; the word is accepted in the first IDLE cycle.
- Reset mid-operation: aborts immediately.
  - No further beats, and done is NOT pulsed for the aborted word.
  - The word is lost; upstream must resend it.
- Reset with valid in the same cycle: reset wins and nothing is captured.
- Arithmetic: idx is SEL_W bits wide. No wrap-around is possible because the scan is a priority encode, not a counter.

Decomposition:
- Shared package holds:
  - Constants SEL_W and N_OUT.
  - State enum: IDLE, SHIFT, DONE.
  - Select code type, logic [SEL_W-1:0].
- One sub-module, lsb_first_finder: combinational priority encoder over N_OUT bits.
  - Outputs: index of the lowest set bit; any flag (high when any bit is set); last flag (high when exactly one bit is set).
  - Reused by other routing blocks.
- The state machine and registers stay in the top module.

Test Plan:
- Full word: data_in = 8'hA5, mask_in = 8'hFF, one-cycle valid.
  - Required response: beats on cycles 1..8 with sel = 0..7 and dout = 1,0,1,0,0,1,0,1.
  - done = 1 on cycle 9; ready = 1 on cycle 10.
- Sparse mask: data_in = 8'h80, mask_in = 8'h81.
  - Required response: two beats, (sel 0, dout 0) then (sel 7, dout 1).
  - done on cycle 3; no dout_en on any other channel.
- Empty mask: mask_in = 8'h00.
  - Required response: no dout_en at all; done on cycle 1; ready = 1 on cycle 2.
- Input stability: hold valid high and change data_in to 8'hFF during SHIFT of word 8'h0F (mask 8'hFF).
  - Required response: emitted bits are 1,1,1,1,0,0,0,0.
  - The second word is accepted only in the first IDLE cycle after done.
- Reset mid-operation: assert reset during the 3rd beat.
  - Required response: next cycle dout_en = 0, sel = 0, busy = 0, ready = 1; done never pulses.
- Back-to-back: valid held high with two words, each mask 8'h03.
  - Required response: beats on cycles 1–2, done on cycle 3, second accept on cycle 4, beats on cycles 5–6, done on cycle 7.
